// File: rtl/penta_adder.sv
// Registered base-5 adder: DIGITS quinary digits (3 bits each, values 0-4) plus carry-in.
// Latency 1 cycle, one operand set accepted every cycle; no backpressure, outputs are always valid.
// Any input digit above 4 forces err=1 with sum=0 and cout=0 on the next edge.
module penta_adder #(
    parameter int DIGITS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3*DIGITS-1:0]   a,
    input  logic [3*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic [3*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    logic [3*DIGITS-1:0] sum_nxt;
    logic                carry;
    logic                bad;
    logic [3:0]          t;

    // Ripple from digit 0 upward; t never exceeds 9 when both digits are legal.
    always_comb begin
        sum_nxt = '0;
        carry   = cin;
        bad     = 1'b0;
        t       = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            t = {1'b0, a[3*i +: 3]} + {1'b0, b[3*i +: 3]} + {3'b000, carry};
            if (t >= 4'd5) begin
                sum_nxt[3*i +: 3] = 3'(t - 4'd5);
                carry             = 1'b1;
            end else begin
                sum_nxt[3*i +: 3] = t[2:0];
                carry             = 1'b0;
            end
            if ((a[3*i +: 3] > 3'd4) || (b[3*i +: 3] > 3'd4)) begin
                bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
            err  <= 1'b0;
        end else if (bad) begin
            sum  <= '0;
            cout <= 1'b0;
            err  <= 1'b1;
        end else begin
            sum  <= sum_nxt;
            cout <= carry;
            err  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_penta_adder.sv
// Scoreboard bench for penta_adder: a 1-digit and a 3-digit instance driven side by side.
module tb_penta_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] a1, b1, sum1;
    logic       cin1, cout1, err1;
    logic [8:0] a3, b3, sum3;
    logic       cin3, cout3, err3;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        string       tag;
        bit          wide;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    penta_adder #(.DIGITS(1)) u_d1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1),
        .sum(sum1), .cout(cout1), .err(err1)
    );

    penta_adder #(.DIGITS(3)) u_d3 (
        .clk(clk), .rst(rst), .a(a3), .b(b3), .cin(cin3),
        .sum(sum3), .cout(cout3), .err(err3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            failed++;
            $display("FAIL %s: got {err,cout,sum}=0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pk1(input bit e, input bit c, input int s);
        return {27'd0, e, c, 3'(s)};
    endfunction

    function automatic logic [31:0] pk3(input bit e, input bit c, input int d2, input int d1, input int d0);
        return {21'd0, e, c, 3'(d2), 3'(d1), 3'(d0)};
    endfunction

    // Reference by integer value: decode both operands, add, re-encode in base 5.
    function automatic logic [31:0] model(input logic [8:0] a, input logic [8:0] b,
                                          input bit c, input int nd, input bit r);
        int   va = 0, vb = 0, p = 1, tot;
        bit   ill = 1'b0;
        logic [8:0] s = '0;
        int   co;
        if (r) return 32'd0;
        for (int i = 0; i < nd; i++) begin
            if (a[3*i +: 3] > 3'd4 || b[3*i +: 3] > 3'd4) ill = 1'b1;
            va += int'(a[3*i +: 3]) * p;
            vb += int'(b[3*i +: 3]) * p;
            p  *= 5;
        end
        if (ill) return 32'd1 << (3*nd + 1);
        tot = va + vb + int'(c);
        co  = (tot >= p) ? 1 : 0;
        tot = tot % p;
        for (int i = 0; i < nd; i++) begin
            s[3*i +: 3] = 3'(tot % 5);
            tot = tot / 5;
        end
        return (32'(co) << (3*nd)) | 32'(s);
    endfunction

    // One cycle: drive both instances at the falling edge, push expectations, check after the rising edge.
    task automatic step(input string tag, input bit r,
                        input logic [2:0] ia1, input logic [2:0] ib1, input bit ic1, input logic [31:0] e1,
                        input logic [8:0] ia3, input logic [8:0] ib3, input bit ic3, input logic [31:0] e3);
        exp_t x;
        @(negedge clk);
        rst = r;
        a1 = ia1; b1 = ib1; cin1 = ic1;
        a3 = ia3; b3 = ib3; cin3 = ic3;
        sb.push_back('{tag: {tag, "/d1"}, wide: 1'b0, exp: e1});
        sb.push_back('{tag: {tag, "/d3"}, wide: 1'b1, exp: e3});
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            if (x.wide) check(x.tag, {21'd0, err3, cout3, sum3}, x.exp);
            else        check(x.tag, {27'd0, err1, cout1, sum1}, x.exp);
        end
    endtask

    initial begin
        logic [2:0] ra1, rb1;
        logic [8:0] ra3, rb3;
        bit         rc1, rc3, rr;

        rst = 1'b1;
        a1 = '0; b1 = '0; cin1 = 1'b0;
        a3 = '0; b3 = '0; cin3 = 1'b0;

        // Reset holds outputs at zero regardless of operands.
        step("rst_hold",  1, 3'd4, 3'd4, 0, pk1(0,0,0), 9'o444, 9'o444, 1, pk3(0,0,0,0,0));
        step("rst_hold2", 1, 3'd4, 3'd4, 0, pk1(0,0,0), 9'o444, 9'o444, 1, pk3(0,0,0,0,0));
        step("rst_rel",   0, 3'd4, 3'd4, 0, pk1(0,1,3), 9'o000, 9'o000, 0, pk3(0,0,0,0,0));

        step("0+1",       0, 3'd0, 3'd1, 0, pk1(0,0,1), 9'o000, 9'o000, 0, pk3(0,0,0,0,0));
        step("1+2",       0, 3'd1, 3'd2, 0, pk1(0,0,3), 9'o000, 9'o000, 0, pk3(0,0,0,0,0));
        step("2+2",       0, 3'd2, 3'd2, 0, pk1(0,0,4), 9'o000, 9'o000, 0, pk3(0,0,0,0,0));
        step("4+4",       0, 3'd4, 3'd4, 0, pk1(0,1,3), 9'o000, 9'o000, 0, pk3(0,0,0,0,0));
        step("2+4",       0, 3'd2, 3'd4, 0, pk1(0,1,1), 9'o000, 9'o000, 0, pk3(0,0,0,0,0));
        step("3+4",       0, 3'd3, 3'd4, 0, pk1(0,1,2), 9'o000, 9'o000, 0, pk3(0,0,0,0,0));
        step("2+3",       0, 3'd2, 3'd3, 0, pk1(0,1,0), 9'o000, 9'o000, 0, pk3(0,0,0,0,0));
        step("4+4+c",     0, 3'd4, 3'd4, 1, pk1(0,1,4), 9'o000, 9'o000, 0, pk3(0,0,0,0,0));
        step("0+0+c",     0, 3'd0, 3'd0, 1, pk1(0,0,1), 9'o000, 9'o000, 1, pk3(0,0,0,0,1));

        // Illegal digits, then recovery.
        step("ill_4_5",   0, 3'd4, 3'd5, 0, pk1(1,0,0), 9'o000, 9'o000, 0, pk3(0,0,0,0,0));
        step("ill_7_5",   0, 3'd7, 3'd5, 1, pk1(1,0,0), 9'o000, 9'o000, 0, pk3(0,0,0,0,0));
        step("rec_1_1",   0, 3'd1, 3'd1, 0, pk1(0,0,2), 9'o000, 9'o000, 0, pk3(0,0,0,0,0));

        // Three-digit ripple; octal literals map one octal digit onto one 3-bit field.
        step("444+001",   0, 3'd0, 3'd0, 0, pk1(0,0,0), 9'o444, 9'o001, 0, pk3(0,1,0,0,0));
        step("123+321",   0, 3'd0, 3'd0, 0, pk1(0,0,0), 9'o123, 9'o321, 0, pk3(0,0,4,4,4));
        step("444+444+c", 0, 3'd0, 3'd0, 0, pk1(0,0,0), 9'o444, 9'o444, 1, pk3(0,1,4,4,4));
        step("ill_d0",    0, 3'd0, 3'd0, 0, pk1(0,0,0), 9'o006, 9'o000, 0, pk3(1,0,0,0,0));
        step("ill_d1",    0, 3'd0, 3'd0, 0, pk1(0,0,0), 9'o000, 9'o060, 0, pk3(1,0,0,0,0));
        step("ill_d2",    0, 3'd0, 3'd0, 0, pk1(0,0,0), 9'o644, 9'o000, 1, pk3(1,0,0,0,0));

        // Back-to-back random legal stream with a one-cycle reset in the middle.
        for (int i = 0; i < 20; i++) begin
            ra1 = 3'($urandom_range(0, 4));
            rb1 = 3'($urandom_range(0, 4));
            rc1 = 1'($urandom_range(0, 1));
            rc3 = 1'($urandom_range(0, 1));
            for (int d = 0; d < 3; d++) begin
                ra3[3*d +: 3] = 3'($urandom_range(0, 4));
                rb3[3*d +: 3] = 3'($urandom_range(0, 4));
            end
            rr = (i == 10);
            step($sformatf("rnd%0d", i), rr,
                 ra1, rb1, rc1, model({6'd0, ra1}, {6'd0, rb1}, rc1, 1, rr),
                 ra3, rb3, rc3, model(ra3, rb3, rc3, 3, rr));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
